// File: rtl/router_0_input_ctrl.sv
// router_0_input_ctrl
//    Input-port controller for router 0, mesh node (0,0), of the 2x2 mesh.
//    Reads packets from one first-word-fall-through flit FIFO and XY-routes
//    each header to the Local, East or South output. It holds a one-hot
//    request until the packet's TAIL flit has been forwarded. Headers with an
//    illegal length or an unreachable destination are discarded up to their
//    TAIL.
//
// Ports
//    clk, rst     clock; asynchronous active-high reset
//    fifo_empty   input FIFO empty
//    fifo_dout    head flit (valid whenever fifo_empty=0)
//    fifo_rd      pop strobe (combinational)
//    grant        one-hot grant from output arbiters  [0]=L [1]=E [2]=S
//    out_ready    downstream ready per output (same bit order)
//    req          one-hot request to output arbiters (same bit order)
//    flit_out     forwarded flit (always fifo_dout)
//    flit_valid   one-hot valid per output, asserted on forwarded pops
//    flit_type    type field of the flit popped this cycle in ACTIVE, else 0
//    length       registered length of the current packet
//    err_route    one-cycle pulse: header destination unreachable
//    err_len      one-cycle pulse: illegal length or TAIL count mismatch
module router_0_input_ctrl #(
   parameter int unsigned FLIT_W = 32,
   parameter int unsigned LEN_W  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [FLIT_W-1:0] fifo_dout,
   output logic              fifo_rd,
   input  logic [2:0]        grant,
   input  logic [2:0]        out_ready,
   output logic [2:0]        req,
   output logic [FLIT_W-1:0] flit_out,
   output logic [2:0]        flit_valid,
   output logic [2:0]        flit_type,
   output logic [LEN_W-1:0]  length,
   output logic              err_route,
   output logic              err_len
);

   localparam logic [2:0] TYPE_HEADER = 3'b001;
   localparam logic [2:0] TYPE_TAIL   = 3'b100;

   localparam logic [2:0] PORT_L = 3'b001;
   localparam logic [2:0] PORT_E = 3'b010;
   localparam logic [2:0] PORT_S = 3'b100;

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      ACTIVE = 3'b010,
      DROP   = 3'b100
   } state_t;

   state_t state, state_n;

   logic [2:0]       sel_oh;       // route of the current packet, one-hot
   logic [LEN_W-1:0] length_q;
   logic [LEN_W-1:0] cnt;          // flits popped so far in this packet
   logic             err_route_q;
   logic             err_len_q;

   // Head-flit fields
   logic [2:0]  head_type;
   logic [11:0] hdr_len;
   logic [1:0]  dst_x;
   logic [1:0]  dst_y;
   logic [2:0]  route_oh;
   logic        route_bad;
   logic        len_bad;

   // Next-state controls
   logic             load_hdr;
   logic             set_err_route;
   logic             set_err_len;
   logic             tail_mismatch;
   logic             fwd_pop;
   logic [LEN_W:0]   cnt_inc;

   assign head_type = fifo_dout[31:29];
   assign hdr_len   = fifo_dout[28:17];
   assign dst_x     = fifo_dout[3:2];
   assign dst_y     = fifo_dout[1:0];

   // XY routing from (0,0): X first, then Y, else local.
   always_comb begin
      if (dst_x != 2'd0) begin
         route_oh = PORT_E;
      end else if (dst_y != 2'd0) begin
         route_oh = PORT_S;
      end else begin
         route_oh = PORT_L;
      end
   end

   // The mesh is 2x2, so coordinates above 1 name no node.
   assign route_bad = (dst_x > 2'd1) || (dst_y > 2'd1);
   assign len_bad   = (hdr_len < 12'd2);

   assign cnt_inc  = {1'b0, cnt} + 1'b1;
   assign flit_out = fifo_dout;

   always_comb begin
      state_n       = state;
      fifo_rd       = 1'b0;
      req           = '0;
      flit_valid    = '0;
      flit_type     = '0;
      load_hdr      = 1'b0;
      set_err_route = 1'b0;
      set_err_len   = 1'b0;
      tail_mismatch = 1'b0;
      fwd_pop       = 1'b0;

      // Outputs are held quiet while reset is asserted so the FIFO is never
      // popped during reset, even if a stray flit sits at its head.
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  if (head_type == TYPE_HEADER) begin
                     if (len_bad || route_bad) begin
                        set_err_len   = len_bad;
                        set_err_route = route_bad;
                        state_n       = DROP;
                     end else begin
                        load_hdr = 1'b1;
                        state_n  = ACTIVE;
                     end
                  end else begin
                     // Stray non-header flit: discard silently.
                     fifo_rd = 1'b1;
                  end
               end
            end

            ACTIVE: begin
               req     = sel_oh;
               fifo_rd = (|(grant & out_ready & sel_oh)) & ~fifo_empty;
               if (fifo_rd) begin
                  fwd_pop    = 1'b1;
                  flit_valid = sel_oh;
                  flit_type  = head_type;
                  if (head_type == TYPE_TAIL) begin
                     state_n       = IDLE;
                     tail_mismatch = (cnt_inc != {1'b0, length_q});
                  end
               end
            end

            DROP: begin
               fifo_rd = ~fifo_empty;
               if (fifo_rd && (head_type == TYPE_TAIL)) begin
                  state_n = IDLE;
               end
            end

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_oh      <= '0;
         length_q    <= '0;
         cnt         <= '0;
         err_route_q <= 1'b0;
         err_len_q   <= 1'b0;
      end else begin
         err_route_q <= set_err_route;
         err_len_q   <= set_err_len | tail_mismatch;
         if (load_hdr) begin
            sel_oh   <= route_oh;
            length_q <= LEN_W'(hdr_len);
            cnt      <= '0;
         end else if (fwd_pop && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign length    = length_q;
   assign err_route = err_route_q;
   assign err_len   = err_len_q;

endmodule

// File: doc/router_0_input_ctrl.md
# router_0_input_ctrl

Input-port controller for router 0 (mesh node (0,0)) of the 2x2 2D mesh. It reads packets from one input FWFT flit FIFO, XY-routes each header, and raises a request toward the Local, East or South output arbiter. It holds that request until the packet's TAIL flit has been forwarded, and it supplies the flit type and packet length that the arbiter's packet timer consumes. It is the requesting end of the arbiter's req/grant handshake, and one instance sits behind each input FIFO of router 0.

## Interface
- FLIT_W, 32: flit width; must be ≥ 32.
- LEN_W, 12: packet-length field width. This matches the arbiter length input.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  input FIFO empty.
- fifo_dout  in  FLIT_W  head flit; valid whenever fifo_empty=0 (first-word fall-through).
- fifo_rd  out  1  pop strobe; combinational.
- grant  in  3  one-hot grant from the output arbiters: [0]=L, [1]=E, [2]=S.
- out_ready  in  3  downstream ready per output, same bit order as grant.
- req  out  3  one-hot request to the output arbiters, same bit order.
- flit_out  out  FLIT_W  forwarded flit; equals fifo_dout.
- flit_valid  out  3  one-hot valid per output; equals fifo_rd in ACTIVE, routed to sel.
- flit_type  out  3  type of the flit popped this cycle; 3'b000 when no pop.
- length  out  LEN_W  registered length of the current packet.
- err_route  out  1  one-cycle pulse: header addressed outside router 0's reachable set.
- err_len  out  1  one-cycle pulse: illegal length field, or TAIL count mismatch.

## Operation
- Flit fields:
  - type = flit[31:29]: HEADER=3'b001, PAYLOAD=3'b010, TAIL=3'b100.
  - Header length = flit[28:17]: total flits including header and tail.
  - Header dst_x = flit[3:2], dst_y = flit[1:0].
- Routing (XY, current node (0,0)), evaluated in priority order:
  - dst_x > 0 → E.
  - else dst_y > 0 → S.
  - else → L.
  - Because the node is (0,0), no destination requires W or N.
- States: IDLE, ACTIVE, DROP. Encoding is one-hot.
- IDLE:
  - Head flit is HEADER with length ≥ 2: register sel (route) and length; clear flit counter cnt; next state ACTIVE. No pop.
  - Head flit is HEADER with length < 2: pulse err_len; next state DROP. No pop in IDLE.
  - Head flit is not HEADER (stray): pop it (fifo_rd=1); stay IDLE; no error pulse.
  - FIFO empty: stay IDLE.
- ACTIVE:
  - req = onehot(sel) on every ACTIVE cycle.
  - fifo_rd = grant[sel] & out_ready[sel] & ~fifo_empty.
  - Each pop increments cnt (LEN_W bits, saturating).
  - Popped flit is TAIL: next state IDLE. If cnt+1 ≠ length, pulse err_len in the cycle after the pop; the packet still completes normally.
  - Grant removed mid-packet (arbiter timer expiry): stall with req held, no pop, resume when grant returns.
  - A HEADER popped while in ACTIVE is forwarded as-is; it neither reroutes nor ends the packet.
- DROP:
  - Entered from IDLE on any illegal header. A header with illegal length reports err_len; no destination at (0,0) reports err_route.
  - fifo_rd = ~fifo_empty; every popped flit is discarded and flit_valid stays 0.
  - Popped flit is TAIL: next state IDLE.
- flit_type output: type field of fifo_dout when fifo_rd=1 in ACTIVE, otherwise 0. This drives the arbiter timer's HEADER-triggered length load.

## Timing
- Reset values: state IDLE; req, flit_valid, flit_type, err_route and err_len all 0; length 0; cnt 0.
- Reset asserted mid-packet returns to IDLE immediately and asynchronously. The FIFO is not popped and is reset separately.
- Header visible at cycle t (in IDLE) → req high from t+1.
- Grant observed at cycle t+k with out_ready=1 → header popped and forwarded in that same cycle (combinational path).
- With grant and ready held continuously, one flit per cycle. An N-flit packet occupies ACTIVE for N cycles after the first grant.
- TAIL popped at cycle u → req low at u+1.
  - Next header is examined at u+1, giving back-to-back req at u+2.
  - Between packets req drops for exactly one cycle (u+1). The arbiter's IDLE/re-grant logic relies on this gap.
- err_route, err_len and ACTIVE timing:
  - A header-check error (bad route or length < 2) detected in IDLE at cycle t pulses at t+1. This is the first DROP cycle.
  - err_len for a TAIL-count mismatch pulses in the cycle after the TAIL pop, the first IDLE cycle.
- fifo_rd never asserts while fifo_empty=1 in any state.

## Test plan
- 4-flit packet dst (1,0), len=4, grant[1] and out_ready high → req=3'b010 from t+1; 4 consecutive pops; flit_type sequence 001,010,010,100; req low the cycle after TAIL; no errors.
- Two back-to-back 2-flit packets, dst (0,1) then (0,0) → req 3'b100, one-cycle gap, then 3'b001; each packet forwarded only to its own flit_valid bit.
- Grant withdrawn for 3 cycles mid-packet, and separately out_ready=0 for 2 cycles → no pops and req held during each stall; the remaining flits complete in order.
- Header len=1 → err_len pulse at t+1 and whole packet discarded. Header len=5 on a 3-flit packet → err_len pulse one cycle after the TAIL pop, packet still forwarded.
- Stray PAYLOAD at head while IDLE → popped and dropped with no error; the following valid header is routed normally.
- Reset asserted asynchronously mid-packet → req, flit_valid and flit_type drop to 0 immediately; state is IDLE after release.
